mem_arbiter: RTL and testbench

Shares one single-ported, variable-latency unified memory between the instruction-fetch port (IF) and the load/store port (MEM) of the 5-stage pipeline. Serialises requests through a small FSM and registers the memory-side request. Captures returned data and generates per-port stall requests that feed the existing stall unit (stall_req_id/ex/mem and the IF stall path). A timeout guard keeps a hung memory from deadlocking the core.

---
 rtl/riscv_mem_pkg.sv | 12 +
 rtl/mem_timeout_ctr.sv | 33 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified-memory arbiter: data width, the abort
// instruction, and the arbiter state encoding.
package riscv_mem_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;
endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles without an ack; tc_o flags the last allowed cycle.
// TIMEOUT = 0 keeps tc_o low forever.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (TIMEOUT != 0) && (cnt_q == LAST);
endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF and MEM accesses onto one variable-latency memory, returns
// data with one-cycle valid pulses and raises per-port stall requests.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned     TIMEOUT = 64,
    parameter logic [XLEN-1:0] NOP     = NOP_INSN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_ce_i,
    input  logic [XLEN-1:0] inst_addr_i,
    output logic [XLEN-1:0] inst_o,
    output logic            inst_valid_o,
    input  logic            data_ce_i,
    input  logic            data_we_i,
    input  logic [XLEN-1:0] data_addr_i,
    input  logic [XLEN-1:0] data_wdata_i,
    output logic [XLEN-1:0] data_rdata_o,
    output logic            data_valid_o,
    output logic            if_stall_req_o,
    output logic            mem_stall_req_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_ack_i,
    output logic            err_o
);
    arb_state_e      state_q;
    logic [XLEN-1:0] tag_q, inst_q, drd_q, addr_q, wdata_q;
    logic            iv_q, dv_q, req_q, we_q, err_q;
    logic            busy, tmo;

    assign busy = (state_q != ST_IDLE);

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!busy || mem_ack_i || tmo),
        .en_i  (busy && !mem_ack_i),
        .tc_o  (tmo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tag_q   <= '0;
            inst_q  <= NOP;
            drd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            iv_q    <= 1'b0;
            dv_q    <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            iv_q <= 1'b0;
            dv_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A port pulsing valid this cycle advances at this edge, so skip it
                    if (data_ce_i && !dv_q) begin
                        addr_q  <= data_addr_i;
                        we_q    <= data_we_i;
                        wdata_q <= data_wdata_i;
                        req_q   <= 1'b1;
                        state_q <= ST_BUSY_D;
                    end else if (inst_ce_i && !iv_q) begin
                        addr_q  <= inst_addr_i;
                        tag_q   <= inst_addr_i;
                        we_q    <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= ST_BUSY_I;
                    end
                end
                ST_BUSY_I: begin
                    if (mem_ack_i || tmo) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        inst_q  <= mem_ack_i ? mem_rdata_i : NOP;
                        iv_q    <= inst_ce_i && (inst_addr_i == tag_q);
                        if (!mem_ack_i)
                            err_q <= 1'b1;
                    end
                end
                ST_BUSY_D: begin
                    if (mem_ack_i || tmo) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        dv_q    <= 1'b1;
                        if (!mem_ack_i) begin
                            drd_q <= '0;
                            err_q <= 1'b1;
                        end else if (!we_q) begin
                            drd_q <= mem_rdata_i;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign inst_o          = inst_q;
    assign inst_valid_o    = iv_q;
    assign data_rdata_o    = drd_q;
    assign data_valid_o    = dv_q;
    assign mem_req_o       = req_q;
    assign mem_we_o        = we_q;
    assign mem_addr_o      = addr_q;
    assign mem_wdata_o     = wdata_q;
    assign err_o           = err_q;
    // Stall paths see only port inputs and registered valids, never mem_ack_i
    assign if_stall_req_o  = inst_ce_i & ~iv_q;
    assign mem_stall_req_o = data_ce_i & ~dv_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random stimulus against a transaction-level model of the
// arbiter, with a responding memory whose latency the bench controls.
module tb_mem_arbiter;
    localparam int unsigned TMO  = 8;
    localparam logic [31:0] NOPI = 32'h0000_0013;
    localparam logic [31:0] K    = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_ce_i, data_ce_i, data_we_i, mem_ack_i;
    logic [31:0] inst_addr_i, data_addr_i, data_wdata_i, mem_rdata_i;
    logic [31:0] inst_o, data_rdata_o, mem_addr_o, mem_wdata_o;
    logic        inst_valid_o, data_valid_o, if_stall_req_o, mem_stall_req_o;
    logic        mem_req_o, mem_we_o, err_o;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TMO), .NOP(NOPI)) dut (
        .clk(clk), .rst(rst),
        .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i), .inst_o(inst_o),
        .inst_valid_o(inst_valid_o),
        .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
        .data_valid_o(data_valid_o),
        .if_stall_req_o(if_stall_req_o), .mem_stall_req_o(mem_stall_req_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i), .err_o(err_o)
    );

    int n_cmp = 0, n_fail = 0;
    bit chk_en = 0;

    // Model: one outstanding transaction record plus the expected outputs.
    bit          m_busy, m_isd;
    logic [31:0] m_tag;
    int          m_el;
    logic [31:0] e_inst, e_drd, e_addr, e_wdata;
    logic        e_iv, e_dv, e_req, e_we, e_err;

    // Memory responder controls
    int          req_cyc = 0, lat = 0;
    bit          hang = 0, spur_en = 0, rand_lat = 0, rd_ovr_en = 0;
    logic [31:0] rd_ovr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit nv_i, nv_d, ab;
        nv_i = 0; nv_d = 0; ab = 0;
        if (rst) begin
            m_busy = 0; m_isd = 0; m_tag = '0; m_el = 0;
            e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
            e_drd = '0; e_inst = NOPI; e_err = 0;
        end else if (!m_busy) begin
            if (data_ce_i && !e_dv) begin
                m_busy = 1; m_isd = 1; m_el = 0;
                e_req = 1; e_addr = data_addr_i; e_we = data_we_i; e_wdata = data_wdata_i;
            end else if (inst_ce_i && !e_iv) begin
                m_busy = 1; m_isd = 0; m_el = 0; m_tag = inst_addr_i;
                e_req = 1; e_addr = inst_addr_i; e_we = 0;
            end
        end else begin
            ab = !mem_ack_i && (TMO > 0) && (m_el == int'(TMO) - 1);
            if (mem_ack_i || ab) begin
                if (m_isd) begin
                    nv_d = 1;
                    if (ab) e_drd = '0;
                    else if (!e_we) e_drd = mem_rdata_i;
                end else begin
                    e_inst = ab ? NOPI : mem_rdata_i;
                    nv_i = inst_ce_i && (inst_addr_i == m_tag);
                end
                if (ab) e_err = 1;
                m_busy = 0; e_req = 0; e_we = 0;
            end else begin
                m_el++;
            end
        end
        e_iv = nv_i; e_dv = nv_d;
    endtask

    task automatic responder();
        mem_ack_i = 1'b0;
        mem_rdata_i = $urandom;
        if (e_req) begin
            req_cyc++;
            if (req_cyc == 1 && rand_lat) lat = $urandom_range(0, 11);
            if (!hang && req_cyc == lat + 1) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = rd_ovr_en ? rd_ovr : (e_addr ^ K);
            end
        end else begin
            req_cyc = 0;
            if (spur_en && $urandom_range(0, 3) == 0) mem_ack_i = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        responder();
    endtask

    task automatic wait_pulse(input bit d, output int n);
        bit got;
        n = 0; got = 0;
        while (!got && n < 40) begin
            tick();
            n++;
            got = d ? (data_valid_o === 1'b1) : (inst_valid_o === 1'b1);
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL pulse_timeout: no %s valid within %0d cycles", d ? "data" : "inst", n);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("inst_o", inst_o, e_inst);
            chk("inst_valid_o", 32'(inst_valid_o), 32'(e_iv));
            chk("data_rdata_o", data_rdata_o, e_drd);
            chk("data_valid_o", 32'(data_valid_o), 32'(e_dv));
            chk("mem_req_o", 32'(mem_req_o), 32'(e_req));
            chk("mem_we_o", 32'(mem_we_o), 32'(e_we));
            chk("mem_addr_o", mem_addr_o, e_addr);
            chk("mem_wdata_o", mem_wdata_o, e_wdata);
            chk("err_o", 32'(err_o), 32'(e_err));
            chk("if_stall", 32'(if_stall_req_o), 32'(inst_ce_i & ~e_iv));
            chk("mem_stall", 32'(mem_stall_req_o), 32'(data_ce_i & ~e_dv));
        end
    end

    initial begin
        int n;
        rst = 1; inst_ce_i = 0; inst_addr_i = '0; data_ce_i = 0; data_we_i = 0;
        data_addr_i = '0; data_wdata_i = '0; mem_ack_i = 0; mem_rdata_i = '0;
        e_iv = 0; e_dv = 0;
        tick();
        chk_en = 1;
        tick();
        chk("rst_inst_o", inst_o, NOPI);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_drd", data_rdata_o, 32'd0);
        rst = 0;

        // Plain fetch, ack 3 cycles after the request appears
        lat = 3; rd_ovr_en = 1; rd_ovr = 32'h0050_0093;
        inst_ce_i = 1; inst_addr_i = 32'h100;
        wait_pulse(0, n);
        chk("t1_latency", 32'(n), 32'd5);
        chk("t1_inst", inst_o, 32'h0050_0093);
        chk("t1_if_stall", 32'(if_stall_req_o), 32'd0);
        chk("t1_err", 32'(err_o), 32'd0);
        inst_ce_i = 0; rd_ovr_en = 0;
        tick();

        // Simultaneous fetch and load: data goes first
        lat = 1;
        inst_ce_i = 1; inst_addr_i = 32'h300;
        data_ce_i = 1; data_we_i = 0; data_addr_i = 32'h200;
        tick();
        chk("t2_first_addr", mem_addr_o, 32'h200);
        wait_pulse(1, n);
        chk("t2_load", data_rdata_o, 32'h200 ^ K);
        chk("t2_no_inst_yet", 32'(inst_valid_o), 32'd0);
        data_ce_i = 0;
        wait_pulse(0, n);
        chk("t2_inst", inst_o, 32'h300 ^ K);
        inst_ce_i = 0;
        tick();

        // Store: read data holds its previous value
        lat = 1;
        data_ce_i = 1; data_we_i = 1; data_addr_i = 32'h204; data_wdata_i = 32'hDEAD_BEEF;
        tick();
        chk("t3_we", 32'(mem_we_o), 32'd1);
        chk("t3_addr", mem_addr_o, 32'h204);
        chk("t3_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        wait_pulse(1, n);
        chk("t3_latency", 32'(n), 32'd2);
        chk("t3_drd_held", data_rdata_o, 32'h200 ^ K);
        data_ce_i = 0; data_we_i = 0;
        tick();

        // Redirect mid-fetch: stale result dropped, new fetch delivered
        lat = 5;
        inst_ce_i = 1; inst_addr_i = 32'h100;
        tick(); tick();
        inst_addr_i = 32'h180;
        wait_pulse(0, n);
        chk("t4_latency", 32'(n), 32'd12);
        chk("t4_inst", inst_o, 32'h180 ^ K);
        inst_ce_i = 0;
        tick();

        // Hung memory: abort after TMO busy cycles, sticky error, late ack ignored
        hang = 1;
        data_ce_i = 1; data_we_i = 0; data_addr_i = 32'h208;
        wait_pulse(1, n);
        chk("t5_latency", 32'(n), 32'd9);
        chk("t5_drd", data_rdata_o, 32'd0);
        chk("t5_err", 32'(err_o), 32'd1);
        chk("t5_req", 32'(mem_req_o), 32'd0);
        data_ce_i = 0; hang = 0;
        tick();
        mem_ack_i = 1;
        tick();
        chk("t5_err_sticky", 32'(err_o), 32'd1);
        chk("t5_no_dv", 32'(data_valid_o), 32'd0);

        // Ack in the timeout cycle completes normally
        rst = 1; tick(); rst = 0;
        lat = 7;
        data_ce_i = 1; data_addr_i = 32'h20C;
        wait_pulse(1, n);
        chk("t5b_latency", 32'(n), 32'd9);
        chk("t5b_drd", data_rdata_o, 32'h20C ^ K);
        chk("t5b_err", 32'(err_o), 32'd0);
        data_ce_i = 0;
        tick();

        // Reset in the second busy cycle, ack arrives afterwards
        lat = 5;
        inst_ce_i = 1; inst_addr_i = 32'h400;
        tick(); tick();
        rst = 1;
        tick();
        rst = 0; inst_ce_i = 0;
        mem_ack_i = 1; mem_rdata_i = 32'h0000_0BAD;
        tick();
        chk("t6_iv", 32'(inst_valid_o), 32'd0);
        chk("t6_req", 32'(mem_req_o), 32'd0);
        chk("t6_inst", inst_o, NOPI);
        chk("t6_addr", mem_addr_o, 32'd0);
        chk("t6_err", 32'(err_o), 32'd0);

        // Random traffic
        spur_en = 1; rand_lat = 1;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) inst_ce_i = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) inst_addr_i = 32'h100 + 32'($urandom_range(0, 3)) * 4;
            if ($urandom_range(0, 3) == 0) data_ce_i = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin
                data_we_i = $urandom_range(0, 1);
                data_addr_i = 32'h200 + 32'($urandom_range(0, 7)) * 4;
                data_wdata_i = $urandom;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
